// File: rtl/interrupt_ctrl.sv
// Interrupt controller: synchronised irq lines, edge/level pending capture,
// mask/disable gating, fixed-priority vectoring and a small cp0-style register file.
module interrupt_ctrl #(
    parameter int unsigned         CHANNELS   = 3,
    parameter logic [31:0]         VEC_BASE   = 32'h0000_0400,
    parameter logic [31:0]         VEC_STRIDE = 32'h0000_0200,
    parameter logic [CHANNELS-1:0] EDGE_RST   = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic                take_ok,
    input  logic [31:0]         pc_next,
    input  logic                eret,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    output logic                irq_take,
    output logic [31:0]         irq_vector,
    output logic [31:0]         epc
);

    localparam int unsigned IDW = 4;

    localparam logic [4:0] ADDR_EPC     = 5'h0E;
    localparam logic [4:0] ADDR_DISABLE = 5'h16;
    localparam logic [4:0] ADDR_MASK    = 5'h17;
    localparam logic [4:0] ADDR_PENDING = 5'h18;
    localparam logic [4:0] ADDR_MODE    = 5'h19;
    localparam logic [4:0] ADDR_CAUSE   = 5'h1A;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] sync3_q, sync3_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic                dis_q, dis_d;
    logic [31:0]         epc_q, epc_d;
    logic                cause_valid_q, cause_valid_d;
    logic [IDW-1:0]      cause_id_q, cause_id_d;

    logic [CHANNELS-1:0] elig_c;
    logic [IDW-1:0]      win_id_c;
    logic                take_c;
    logic                wr_epc_c, wr_dis_c, wr_mask_c, wr_pend_c, wr_mode_c;

    // Highest eligible index wins; the ascending loop leaves the top match.
    always_comb begin
        elig_c   = pending_q & mask_q;
        win_id_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (elig_c[i]) begin
                win_id_c = IDW'(i);
            end
        end
        take_c = (|elig_c) & ~dis_q & ~eret & take_ok;
    end

    assign irq_take   = take_c;
    assign irq_vector = take_c ? (VEC_BASE + 32'(win_id_c) * VEC_STRIDE) : 32'h0;
    assign epc        = epc_q;

    assign wr_epc_c  = cp0_we && (cp0_addr == ADDR_EPC);
    assign wr_dis_c  = cp0_we && (cp0_addr == ADDR_DISABLE);
    assign wr_mask_c = cp0_we && (cp0_addr == ADDR_MASK);
    assign wr_pend_c = cp0_we && (cp0_addr == ADDR_PENDING);
    assign wr_mode_c = cp0_we && (cp0_addr == ADDR_MODE);

    // Next-state logic; a take outranks software writes, eret outranks disable writes.
    always_comb begin
        sync1_d       = irq_in;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;
        edge_d        = sync2_q & ~sync3_q;
        pending_d     = pending_q;
        mask_d        = mask_q;
        mode_d        = mode_q;
        dis_d         = dis_q;
        epc_d         = epc_q;
        cause_valid_d = cause_valid_q;
        cause_id_d    = cause_id_q;

        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (mode_q[i]) begin
                if (wr_pend_c && cp0_wdata[i]) begin
                    pending_d[i] = 1'b0;
                end
                if (take_c && (win_id_c == IDW'(i))) begin
                    pending_d[i] = 1'b0;
                end
                if (edge_q[i]) begin
                    pending_d[i] = 1'b1;
                end
            end else begin
                pending_d[i] = sync3_q[i];
            end
        end

        if (wr_mask_c) begin
            mask_d = cp0_wdata[CHANNELS-1:0];
        end
        if (wr_mode_c) begin
            mode_d = cp0_wdata[CHANNELS-1:0];
        end

        if (take_c) begin
            dis_d         = 1'b1;
            epc_d         = pc_next;
            cause_valid_d = 1'b1;
            cause_id_d    = win_id_c;
        end else begin
            if (wr_epc_c) begin
                epc_d = cp0_wdata;
            end
            if (eret) begin
                dis_d         = 1'b0;
                cause_valid_d = 1'b0;
            end else if (wr_dis_c) begin
                dis_d = cp0_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            edge_q        <= '0;
            pending_q     <= '0;
            mask_q        <= '0;
            mode_q        <= EDGE_RST;
            dis_q         <= 1'b1;
            epc_q         <= '0;
            cause_valid_q <= 1'b0;
            cause_id_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            edge_q        <= edge_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            dis_q         <= dis_d;
            epc_q         <= epc_d;
            cause_valid_q <= cause_valid_d;
            cause_id_q    <= cause_id_d;
        end
    end

    // Register read mux; narrow fields zero-extend, unmapped addresses read zero.
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            ADDR_EPC:     cp0_rdata = epc_q;
            ADDR_DISABLE: cp0_rdata = 32'(dis_q);
            ADDR_MASK:    cp0_rdata = 32'(mask_q);
            ADDR_PENDING: cp0_rdata = 32'(pending_q);
            ADDR_MODE:    cp0_rdata = 32'(mode_q);
            ADDR_CAUSE:   cp0_rdata = {cause_valid_q, 27'h0, cause_id_q};
            default:      cp0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: expected takes are queued by the stimulus
// and popped by a negedge monitor; register state is checked through cp0 reads.
module tb_interrupt_ctrl;

    localparam logic [4:0] A_EPC  = 5'h0E;
    localparam logic [4:0] A_DIS  = 5'h16;
    localparam logic [4:0] A_MASK = 5'h17;
    localparam logic [4:0] A_PEND = 5'h18;
    localparam logic [4:0] A_MODE = 5'h19;
    localparam logic [4:0] A_CAUS = 5'h1A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  irq_in = '0;
    logic        take_ok = 1'b1;
    logic [31:0] pc_next = '0;
    logic        eret = 1'b0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic        irq_take;
    logic [31:0] irq_vector;
    logic [31:0] epc;

    typedef struct {
        logic [31:0] vec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    interrupt_ctrl #(.CHANNELS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .take_ok   (take_ok),
        .pc_next   (pc_next),
        .eret      (eret),
        .cp0_we    (cp0_we),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .irq_take  (irq_take),
        .irq_vector(irq_vector),
        .epc       (epc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every take must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (irq_take !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_take actual=%h required=none", irq_vector);
            end else begin
                e = exp_q.pop_front();
                chk("take_vector", irq_vector, e.vec);
                if (e.cyc >= 0) chk("take_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick(1);
        cp0_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] req, input string nm);
        cp0_addr = a;
        #1;
        chk(nm, cp0_rdata, req);
    endtask

    task automatic pulse(input logic [2:0] v);
        irq_in = v;
        tick(1);
        irq_in = '0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    task automatic push(input logic [31:0] v, input int c);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_take", 32'(irq_take), 32'h0);
        chk("rst_vector", irq_vector, 32'h0);
        rd(A_DIS, 32'h1, "rst_disable");
        rd(A_MODE, 32'h7, "rst_mode");
        rd(A_MASK, 32'h0, "rst_mask");
        #14 rst_n = 1'b1;
        tick(1);

        // Basic take on channel 1
        wr(A_MASK, 32'h7);
        wr(A_DIS, 32'h0);
        pc_next = 32'h0000_0124;
        push(32'h600, cyc + 4);
        pulse(3'b010);
        tick(8);
        rd(A_EPC, 32'h124, "basic_epc");
        rd(A_CAUS, 32'h8000_0001, "basic_cause");
        rd(A_PEND, 32'h0, "basic_pending");
        rd(A_DIS, 32'h1, "basic_disable");
        chk("basic_queue", 32'(exp_q.size()), 32'h0);

        // Priority: channel 2 before channel 0
        do_eret();
        push(32'h800, -1);
        pulse(3'b101);
        tick(8);
        rd(A_PEND, 32'h1, "prio_pending_after_first");
        rd(A_CAUS, 32'h8000_0002, "prio_cause");
        push(32'h400, -1);
        do_eret();
        tick(3);
        rd(A_PEND, 32'h0, "prio_pending_after_second");
        chk("prio_queue", 32'(exp_q.size()), 32'h0);

        // Stall and mask
        take_ok = 1'b0;
        do_eret();
        pulse(3'b100);
        tick(10);
        rd(A_PEND, 32'h4, "stall_pending");
        wr(A_MASK, 32'h3);
        take_ok = 1'b1;
        tick(5);
        rd(A_PEND, 32'h4, "masked_pending");
        push(32'h800, -1);
        wr(A_MASK, 32'h7);
        tick(3);
        chk("stall_queue", 32'(exp_q.size()), 32'h0);

        // Level mode on channel 0
        wr(A_MODE, 32'h0);
        do_eret();
        push(32'h400, -1);
        irq_in = 3'b001;
        tick(8);
        rd(A_CAUS, 32'h8000_0000, "level_cause");
        push(32'h400, -1);
        do_eret();
        tick(3);
        rd(A_PEND, 32'h1, "level_pending_high");
        wr(A_PEND, 32'h1);
        rd(A_PEND, 32'h1, "level_w1c_ignored");
        irq_in = 3'b000;
        tick(4);
        rd(A_PEND, 32'h0, "level_pending_drop");
        wr(A_MODE, 32'h7);
        chk("level_queue", 32'(exp_q.size()), 32'h0);

        // Collisions: W1C vs new edge, then epc write on the take cycle
        do_eret();
        wr(A_MASK, 32'h5);
        pulse(3'b010);
        tick(6);
        rd(A_PEND, 32'h2, "coll_pending_pre");
        irq_in = 3'b010;
        @(posedge clk); #1 irq_in = 3'b000;
        @(posedge clk);
        @(posedge clk); #1;
        wr(A_PEND, 32'h2);
        rd(A_PEND, 32'h2, "coll_set_beats_w1c");
        pc_next = 32'h0000_0200;
        push(32'h600, -1);
        wr(A_MASK, 32'h7);
        wr(A_EPC, 32'h0000_DEAD);
        rd(A_EPC, 32'h200, "coll_take_beats_epc_write");
        rd(A_PEND, 32'h0, "coll_pending_cleared");
        cp0_we = 1'b1; cp0_addr = A_DIS; cp0_wdata = 32'h1; eret = 1'b1;
        tick(1);
        cp0_we = 1'b0; eret = 1'b0;
        rd(A_DIS, 32'h0, "coll_eret_beats_disable");
        rd(A_CAUS, 32'h0000_0001, "coll_cause_after_eret");
        chk("coll_queue", 32'(exp_q.size()), 32'h0);

        // Reset asserted mid-take
        wr(A_DIS, 32'h1);
        pulse(3'b111);
        tick(6);
        rd(A_PEND, 32'h7, "rst_pre_pending");
        take_ok = 1'b0;
        do_eret();
        take_ok = 1'b1;
        #1;
        chk("pre_reset_take", 32'(irq_take), 32'h1);
        chk("pre_reset_vector", irq_vector, 32'h800);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_take", 32'(irq_take), 32'h0);
        chk("mid_reset_vector", irq_vector, 32'h0);
        rd(A_PEND, 32'h0, "mid_reset_pending");
        rd(A_EPC, 32'h0, "mid_reset_epc");
        rd(A_CAUS, 32'h0, "mid_reset_cause");
        rd(A_DIS, 32'h1, "mid_reset_disable");
        rd(A_MODE, 32'h7, "mid_reset_mode");
        rd(A_MASK, 32'h0, "mid_reset_mask");
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
        wr(A_MASK, 32'h7);
        pulse(3'b001);
        tick(8);
        rd(A_PEND, 32'h1, "post_reset_pending");
        push(32'h400, -1);
        wr(A_DIS, 32'h0);
        tick(4);
        rd(A_EPC, 32'h200, "post_reset_epc");

        chk("final_queue", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
